keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SCAN_DIV, default 10000, clock cycles per row slot (100 us at 100 MHz); legal range is >= 2.
REQ-002 DEBOUNCE_SCANS, default 100, number of consecutive matching samples needed to accept a press or a release; legal range is >= 1.
REQ-003 clk  input  1  system clock (100 MHz).
REQ-004 n_rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 col_in  input  4  keypad columns; active-low, pulled up, asynchronous to clk.
REQ-006 clr  input  1  synchronous clear of value.
REQ-007 row_out  output  4  keypad row drive; active-low, one-hot-zero.
REQ-008 key_code  output  4  last accepted key, encoded {row_idx[1:0], col_idx[1:0]}.
REQ-009 key_valid  output  1  single-cycle pulse when a key is accepted.
REQ-010 key_held  output  1  high while an accepted key has not yet been released.
REQ-011 value  output  8  two-nibble entry register, sized to feed the 7-segment display path.

Function
REQ-012 col_in SHALL pass through a two-flop synchronizer with reset value 4'hF; only the synchronized columns (cols_s) are used.
REQ-013 Sample point: the last cycle of each SCAN_DIV period, counted by a slot counter.
REQ-014 row_out SHALL drive only row row_idx low, i.e. row_out = ~(4'b0001 << row_idx).
REQ-015 The FSM SHALL have exactly three states: SCAN, DEBOUNCE, HELD.
REQ-016 SCAN, at a sample point:
- if cols_s == 4'hF, row_idx increments mod 4 (3 wraps to 0);
- otherwise, latch col_idx = lowest-numbered low column, set the match count to 1, and go to DEBOUNCE with row_idx frozen.
REQ-017 DEBOUNCE, at a sample point:
- if cols_s[col_idx] is low, increment the count;
- otherwise, return to SCAN, zero the count, and advance row_idx.
REQ-018 When the count reaches DEBOUNCE_SCANS (including the detection sample), go to HELD. On the next cycle:
- key_valid = 1 for exactly one cycle;
- key_code = {row_idx, col_idx};
- value = {value[3:0], key_code}.
REQ-019 With DEBOUNCE_SCANS == 1, acceptance SHALL occur directly from the detection sample.
REQ-020 HELD: key_held = 1 and row_idx stays frozen. Count consecutive samples with cols_s[col_idx] high; a low sample resets that count. At DEBOUNCE_SCANS releases, go to SCAN, clear key_held, and advance row_idx.
REQ-021 Other keys pressed during DEBOUNCE or HELD SHALL be ignored; no second key_valid pulse is generated.
REQ-022 clr SHALL set value to 8'h00 and takes priority over a same-cycle key load; key_code is unaffected by clr.
REQ-023 key_code SHALL hold its value between presses.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 On n_rst low, the following SHALL take their reset values immediately, in any state, including mid-debounce or in HELD:
- row_out = 4'b1110;
- key_code = 0, key_valid = 0, key_held = 0, value = 8'h00;
- FSM state = SCAN;
- row_idx = 0, all counters = 0;
- synchronizer flops = 4'hF.
REQ-026 After reset release, scanning SHALL restart at row 0 with a full SCAN_DIV slot.

Structure
REQ-027 The shared package keypad_pkg SHALL hold:
- the FSM state enum (SCAN, DEBOUNCE, HELD);
- the default values of SCAN_DIV and DEBOUNCE_SCANS;
- the key code width constant (4).
REQ-028 The two-flop synchronizer SHALL be a separate sub-module, sync2, parameterized by width and reset value.
REQ-029 Counter widths SHALL be derived with $clog2 of the parameters; no magic widths.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3)
REQ-030 Reset test:
- Stimulus: assert n_rst low mid-slot with a key held.
- Response: row_out=1110, key_valid=0, key_held=0, value=00, in the same cycle.
REQ-031 Press test:
- Stimulus: hold row2/col1 closed, so col_in[1] is low whenever row_out=1011.
- Response: exactly one key_valid pulse; key_code=9; value=09; key_held=1; row_out frozen at 1011 until release.
REQ-032 Bounce test:
- Stimulus: col low for 2 samples, then high.
- Response: no key_valid; FSM back to SCAN; row advances to 3.
REQ-033 Sequence test:
- Stimulus: press and release 9, then row3/col0.
- Response: value=9C; key_code=C; two key_valid pulses total.
REQ-034 Multi-column test:
- Stimulus: row0 with cols 1 and 3 low together.
- Response: key_code=1; releasing only col3 keeps key_held=1.
REQ-035 Clear-collision test:
- Stimulus: clr asserted in the key_valid load cycle.
- Response: value=00; key_code still updated.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and defaults for the 4x4 matrix keypad scanner.
// Holds the FSM state enum, the parameter defaults and the key-code width.
package keypad_pkg;

    localparam int SCAN_DIV_DEFAULT       = 10000;
    localparam int DEBOUNCE_SCANS_DEFAULT = 100;
    localparam int KEY_W                  = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Index of the lowest-numbered column pulled low (columns are active-low).
    function automatic logic [1:0] lowest_low(input logic [3:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        if (!cols[0])      idx = 2'd0;
        else if (!cols[1]) idx = 2'd1;
        else if (!cols[2]) idx = 2'd2;
        else if (!cols[3]) idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs; both flops reset to RST_VAL.
module sync2 #(
    parameter int                 WIDTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row strobing, debounced press/release detection,
// and a two-nibble entry register fed by accepted key codes.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = SCAN_DIV_DEFAULT,
    parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEFAULT
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [3:0]       col_in,
    input  logic             clr,
    output logic [3:0]       row_out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held,
    output logic [7:0]       value,
    output state_t           fsm_state
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_SCANS - 1);

    logic [3:0]       cols_s;
    logic [SLOT_W-1:0] slot_cnt;
    logic             sample;

    state_t           state, state_nxt;
    logic [1:0]       row_idx, row_idx_nxt;
    logic [1:0]       col_idx, col_idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept, advance;
    logic             any_low, col_now;
    logic [1:0]       det_col, code_col;

    logic [3:0]       row_out_nxt;
    logic [KEY_W-1:0] key_code_nxt;
    logic             key_valid_nxt, key_held_nxt;
    logic [7:0]       value_nxt;

    sync2 #(
        .WIDTH   (4),
        .RST_VAL (4'hF)
    ) u_col_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (col_in),
        .q     (cols_s)
    );

    // Slot counter: the last cycle of every SCAN_DIV period is the sample point.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) slot_cnt <= '0;
        else if (sample) slot_cnt <= '0;
        else slot_cnt <= slot_cnt + SLOT_W'(1);
    end

    assign sample  = (slot_cnt == SLOT_LAST);
    assign any_low = (cols_s != 4'hF);
    assign col_now = cols_s[col_idx];
    assign det_col = lowest_low(cols_s);
    assign code_col = (state == SCAN) ? det_col : col_idx;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= SCAN;
        else state <= state_nxt;
    end

    // cnt holds matching press samples in DEBOUNCE and release samples in HELD.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        advance   = 1'b0;
        if (sample) begin
            unique case (state)
                SCAN: begin
                    if (any_low) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_nxt = HELD;
                            accept    = 1'b1;
                        end else begin
                            state_nxt = DEBOUNCE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!col_now) begin
                        if (cnt == CNT_LAST) begin
                            state_nxt = HELD;
                            accept    = 1'b1;
                        end
                    end else begin
                        state_nxt = SCAN;
                        advance   = 1'b1;
                    end
                end
                HELD: begin
                    if (col_now && cnt == CNT_LAST) begin
                        state_nxt = SCAN;
                        advance   = 1'b1;
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end
    end

    always_comb begin
        row_idx_nxt   = row_idx;
        col_idx_nxt   = col_idx;
        cnt_nxt       = cnt;
        key_code_nxt  = key_code;
        key_valid_nxt = 1'b0;
        key_held_nxt  = key_held;
        value_nxt     = value;
        if (sample) begin
            unique case (state)
                SCAN: begin
                    if (any_low) begin
                        col_idx_nxt = det_col;
                        cnt_nxt     = CNT_W'(1);
                    end
                end
                DEBOUNCE: cnt_nxt = col_now ? '0 : cnt + CNT_W'(1);
                HELD:     cnt_nxt = col_now ? cnt + CNT_W'(1) : '0;
                default:  cnt_nxt = '0;
            endcase
        end
        if (advance) begin
            row_idx_nxt  = row_idx + 2'd1;
            cnt_nxt      = '0;
            key_held_nxt = 1'b0;
        end
        if (accept) begin
            cnt_nxt       = '0;
            key_valid_nxt = 1'b1;
            key_held_nxt  = 1'b1;
            key_code_nxt  = {row_idx, code_col};
            value_nxt     = {value[3:0], row_idx, code_col};
        end
        if (clr) value_nxt = 8'h00;
        row_out_nxt = ~(4'b0001 << row_idx_nxt);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            row_idx   <= 2'd0;
            col_idx   <= 2'd0;
            cnt       <= '0;
            row_out   <= 4'b1110;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            value     <= 8'h00;
        end else begin
            row_idx   <= row_idx_nxt;
            col_idx   <= col_idx_nxt;
            cnt       <= cnt_nxt;
            row_out   <= row_out_nxt;
            key_code  <= key_code_nxt;
            key_valid <= key_valid_nxt;
            key_held  <= key_held_nxt;
            value     <= value_nxt;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad matrix drives col_in from row_out, and a
// behavioural model of the scan/debounce rules is compared every cycle.
module tb_keypad_scan;
    import keypad_pkg::*;

    localparam int SD = 4;
    localparam int DS = 3;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [3:0]  col_in;
    logic        clr = 1'b0;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [7:0]  value;
    state_t      fsm_state;

    logic [15:0] keys = '0;   // keys[r*4+c] = switch at row r, column c is closed

    int n_checks = 0;
    int n_pass   = 0;
    int n_pulses = 0;

    keypad_scan #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .col_in    (col_in),
        .clr       (clr),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .value     (value),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    // Physical keypad: a closed switch pulls its column low while its row is driven low.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row_out[r])
                for (int c = 0; c < 4; c++)
                    if (keys[r*4+c]) col_in[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: integer phase (0 idle, 1 confirming press, 2 waiting for release).
    int         m_tick, m_row, m_col, m_phase, m_hits, m_rel, m_code, m_value, m_held, m_valid;
    logic [3:0] m_s1, m_s2, m_cs;
    bit         m_sample, m_accept;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_tick = 0; m_row = 0; m_col = 0; m_phase = 0; m_hits = 0; m_rel = 0;
            m_code = 0; m_value = 0; m_held = 0; m_valid = 0;
            m_s1 = 4'hF; m_s2 = 4'hF;
        end else begin
            m_cs = m_s2;
            m_s2 = m_s1;
            m_s1 = col_in;
            m_valid  = 0;
            m_accept = 0;
            m_sample = (m_tick == SD - 1);
            m_tick   = m_sample ? 0 : m_tick + 1;
            if (m_sample) begin
                if (m_phase == 0) begin
                    if (m_cs != 4'hF) begin
                        m_col = 3;
                        for (int c = 3; c >= 0; c--) if (!m_cs[c]) m_col = c;
                        m_hits = 1;
                        if (m_hits >= DS) m_accept = 1;
                        else m_phase = 1;
                    end else m_row = (m_row + 1) % 4;
                end else if (m_phase == 1) begin
                    if (!m_cs[m_col]) begin
                        m_hits++;
                        if (m_hits >= DS) m_accept = 1;
                    end else begin
                        m_phase = 0;
                        m_row = (m_row + 1) % 4;
                    end
                end else begin
                    if (m_cs[m_col]) begin
                        m_rel++;
                        if (m_rel >= DS) begin
                            m_phase = 0;
                            m_held = 0;
                            m_row = (m_row + 1) % 4;
                        end
                    end else m_rel = 0;
                end
            end
            if (m_accept) begin
                m_phase = 2; m_rel = 0; m_valid = 1; m_held = 1;
                m_code  = m_row * 4 + m_col;
                m_value = (m_value % 16) * 16 + m_code;
            end
            if (clr) m_value = 0;
        end
    end

    always @(negedge clk) begin
        if (n_rst) begin
            logic [1:0] exp_st;
            logic [3:0] exp_row;
            exp_st  = (m_phase == 0) ? 2'(SCAN) : (m_phase == 1) ? 2'(DEBOUNCE) : 2'(HELD);
            exp_row = 4'hF;
            exp_row[m_row] = 1'b0;
            check("cycle {row,code,valid,held,value,state}",
                  {12'd0, row_out, key_code, key_valid, key_held, value, 2'(fsm_state)},
                  {12'd0, exp_row, 4'(m_code), 1'(m_valid), 1'(m_held), 8'(m_value), exp_st});
            if (key_valid) n_pulses++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!key_valid && k < 200) begin @(negedge clk); k++; end
        if (k >= 200) check(name, 0, 1);
    endtask

    task automatic wait_released(input string name);
        int k = 0;
        while (key_held && k < 200) begin @(negedge clk); k++; end
        if (k >= 200) check(name, 0, 1);
    endtask

    task automatic wait_state(input state_t s, input string name);
        int k = 0;
        while (fsm_state != s && k < 200) begin @(negedge clk); k++; end
        if (k >= 200) check(name, 0, 1);
    endtask

    initial begin
        int p0;
        tick(3);
        check("reset_row", row_out, 4'b1110);
        check("reset_value", value, 8'h00);
        n_rst = 1'b1;
        // A full first slot at row 0 before the scan moves on.
        tick(3);
        check("first_slot_row0", row_out, 4'b1110);
        tick(1);
        check("first_slot_row1", row_out, 4'b1101);

        // Press row2/col1.
        p0 = n_pulses;
        keys = '0; keys[2*4+1] = 1'b1;
        wait_valid("timeout_press");
        check("press_code", key_code, 4'h9);
        check("press_value", value, 8'h09);
        check("press_held", key_held, 1);
        check("press_row", row_out, 4'b1011);
        tick(40);
        check("press_frozen_row", row_out, 4'b1011);
        check("press_still_held", key_held, 1);
        check("press_one_pulse", n_pulses - p0, 1);
        keys = '0;
        wait_released("timeout_press_release");

        // Bounce: row2/col2 low for two samples, then open.
        keys[2*4+2] = 1'b1;
        wait_state(DEBOUNCE, "timeout_bounce_detect");
        tick(4);
        keys = '0;
        wait_state(SCAN, "timeout_bounce_return");
        tick(1);
        check("bounce_row3", row_out, 4'b0111);
        check("bounce_no_pulse", n_pulses - p0, 1);
        check("bounce_code_kept", key_code, 4'h9);

        // Sequence: row3/col0 after 9.
        keys[3*4+0] = 1'b1;
        wait_valid("timeout_seq");
        check("seq_code", key_code, 4'hC);
        check("seq_value", value, 8'h9C);
        keys = '0;
        wait_released("timeout_seq_release");
        tick(1);
        check("seq_two_pulses", n_pulses - p0, 2);

        // Multi-column: row0 cols 1 and 3 together.
        keys[0*4+1] = 1'b1; keys[0*4+3] = 1'b1;
        wait_valid("timeout_multi");
        check("multi_code", key_code, 4'h1);
        keys[0*4+3] = 1'b0;
        tick(40);
        check("multi_held_col1", key_held, 1);
        keys = '0;
        wait_released("timeout_multi_release");

        // Clear colliding with the load: clr high through debounce and the accept sample.
        keys[1*4+2] = 1'b1;
        wait_state(DEBOUNCE, "timeout_clr_detect");
        clr = 1'b1;
        wait_valid("timeout_clr_valid");
        check("clr_value", value, 8'h00);
        check("clr_code", key_code, 4'h6);
        clr = 1'b0;
        keys = '0;
        wait_released("timeout_clr_release");

        // Randomized presses, bounces, multi-key chords and clears.
        for (int i = 0; i < 40; i++) begin
            keys = '0;
            keys[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
            tick($urandom_range(2, 70));
            keys = '0;
            if ($urandom_range(0, 4) == 0) begin
                clr = 1'b1; tick(1); clr = 1'b0;
            end
            tick($urandom_range(2, 40));
        end
        keys = '0;
        tick(60);

        // Asynchronous reset mid-slot while a key is held.
        keys[1*4+1] = 1'b1;
        wait_state(HELD, "timeout_rst_held");
        tick(1);
        #3 n_rst = 1'b0;
        #1;
        check("rst_row", row_out, 4'b1110);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        check("rst_value", value, 8'h00);
        check("rst_code", key_code, 4'h0);
        check("rst_state", 2'(fsm_state), 2'(SCAN));
        keys = '0;
        tick(2);
        n_rst = 1'b1;
        tick(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
